// File: rtl/ram_fill_checker_if.sv
// RAM-side bus of ram_fill_checker: address, write data/enable and read data.
// master = the fill/check engine, slave = the RAM (or a RAM model).
interface ram_fill_checker_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  modport master (output ram_addr, output ram_wdata, output ram_wren, input ram_q);
  modport slave  (input ram_addr, input ram_wdata, input ram_wren, output ram_q);
endinterface

// File: rtl/ram_fill_checker.sv
// ram_fill_checker: fills a 2^AW-word RAM with (seed + addr) and, with the
// RAM_READBACK_CHECK_EN macro defined, reads it back after GAP idle cycles and
// counts mismatching words (saturating at 63). Without the macro the run ends
// right after the write phase and err_cnt is tied to zero.
module ram_fill_checker #(
  parameter int AW     = 5,
  parameter int DW     = 8,
  parameter int GAP    = 4,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DW-1:0]       seed,
  ram_fill_checker_if.master  ram,
  output logic                busy,
  output logic                done,
  output logic [5:0]          err_cnt
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {IDLE, WRITE, GAP_WAIT, READ, DRAIN, FINISH} state_t;

  state_t        state_q;
  logic [DW-1:0] seed_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_inc;
  logic [DW-1:0] wdata_q;
  logic          wren_q;
  logic          busy_q;
  logic          done_q;

`ifdef RAM_READBACK_CHECK_EN
  logic          rd_q;
  logic [3:0]    wait_q;
  logic [5:0]    err_q;
  logic          pv_q [RD_LAT];
  logic [DW-1:0] pe_q [RD_LAT];
  logic          cmp_fail;
`endif

  // Next sequential address; the counter itself never wraps (held at LAST_ADDR).
  always_comb begin
    addr_inc = addr_q + AW'(1);
  end

  // Run sequencer: phase control with registered RAM strobes and status.
  // WRITE spends one extra edge after the last address to drop ram_wren.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seed_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RAM_READBACK_CHECK_EN
      rd_q    <= 1'b0;
      wait_q  <= '0;
      err_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            seed_q  <= seed;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= WRITE;
`ifdef RAM_READBACK_CHECK_EN
            err_q   <= '0;
`endif
          end
        end
        WRITE: begin
          if (!wren_q) begin
            wren_q  <= 1'b1;
            wdata_q <= seed_q + DW'(addr_q);
          end else if (addr_q != LAST_ADDR) begin
            addr_q  <= addr_inc;
            wdata_q <= seed_q + DW'(addr_inc);
          end else begin
            wren_q  <= 1'b0;
            wdata_q <= '0;
`ifdef RAM_READBACK_CHECK_EN
            wait_q  <= 4'd1;
            state_q <= GAP_WAIT;
`else
            state_q <= FINISH;
`endif
          end
        end
`ifdef RAM_READBACK_CHECK_EN
        GAP_WAIT: begin
          if (wait_q == 4'(GAP)) begin
            addr_q  <= '0;
            rd_q    <= 1'b1;
            state_q <= READ;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        READ: begin
          if (addr_q != LAST_ADDR) begin
            addr_q <= addr_inc;
          end else begin
            rd_q    <= 1'b0;
            wait_q  <= 4'd1;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (wait_q == 4'(RD_LAT)) begin
            state_q <= FINISH;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
`endif
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef RAM_READBACK_CHECK_EN
      if (cmp_fail && (err_q != 6'h3F)) begin
        err_q <= err_q + 6'd1;
      end
`endif
    end
  end

`ifdef RAM_READBACK_CHECK_EN
  // Expected-word pipeline: stage 0 captures the address currently on the bus,
  // so the last stage lines up with ram_q RD_LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pe_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= rd_q;
      pe_q[0] <= seed_q + DW'(addr_q);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  // Mismatch strobe for the word emerging from the pipeline this cycle.
  always_comb begin
    cmp_fail = pv_q[RD_LAT-1] && (ram.ram_q != pe_q[RD_LAT-1]);
  end

  assign err_cnt = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ram.ram_q, 4'(GAP), 2'(RD_LAT)};
  assign err_cnt    = '0;
`endif

  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;
  assign ram.ram_wren  = wren_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: doc/ram_fill_checker.md
RAM_FILL_CHECKER -- requirements
Module: ram_fill_checker

Interface
- REQ-001 SHALL have parameter AW, default 5, meaning RAM address width (depth = 2^AW words).
- REQ-002 SHALL have parameter DW, default 8, meaning RAM data width.
- REQ-003 SHALL have parameter GAP, default 4, meaning idle cycles between write and read phases (valid 1..15).
- REQ-004 SHALL have parameter RD_LAT, default 2, meaning RAM read latency in clocks from address to q (valid 1..2).
- REQ-005 SHALL have port clk, input, 1 bit: the clock; all logic is rising-edge.
- REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-007 SHALL have port start, input, 1 bit: single-cycle request to begin a fill/check run.
- REQ-008 SHALL have port seed, input, DW bits: pattern base, sampled on the accepted start.
- REQ-009 SHALL have port ram_addr, output, AW bits: RAM address.
- REQ-010 SHALL have port ram_wdata, output, DW bits: RAM write data.
- REQ-011 SHALL have port ram_wren, output, 1 bit: RAM write enable.
- REQ-012 SHALL have port ram_q, input, DW bits: RAM read data.
- REQ-013 SHALL have port busy, output, 1 bit: high from the accepted start until done.
- REQ-014 SHALL have port done, output, 1 bit: one-cycle end-of-run pulse.
- REQ-015 SHALL have port err_cnt, output, 6 bits: mismatch count of the last run.

Function
- REQ-016 SHALL implement FSM states IDLE, WRITE, GAP_WAIT, READ, DRAIN, FINISH.
- REQ-017 SHALL, in IDLE, accept start only when not busy, register seed, clear err_cnt, and enter WRITE next cycle; start while busy SHALL be ignored.
- REQ-018 SHALL, in WRITE, drive ram_wren=1, ram_addr=0..2^AW-1 (one per cycle), ram_wdata = (seed_reg + ram_addr) mod 2^DW, then enter GAP_WAIT after the last address.
- REQ-019 SHALL, in GAP_WAIT, hold ram_wren=0 for exactly GAP cycles, then enter READ.
- REQ-020 SHALL, in READ, drive ram_addr=0..2^AW-1 (one per cycle) with ram_wren=0, and push each expected word into an RD_LAT-deep valid/expected pipeline.
- REQ-021 SHALL compare ram_q against the expected word on the cycle the pipeline valid emerges (RD_LAT cycles after that address) and increment err_cnt on mismatch.
- REQ-022 SHALL saturate err_cnt at 63.
- REQ-023 SHALL, in DRAIN, wait RD_LAT cycles for the last compare, then enter FINISH.
- REQ-024 SHALL, in FINISH, pulse done for one cycle, deassert busy on the same edge, and return to IDLE.
- REQ-025 SHALL keep ram_addr wrap-free: the address counter stops at 2^AW-1 and is zeroed on each phase entry.
- REQ-026 SHALL hold err_cnt stable after done until the next accepted start.
- REQ-027 SHALL produce a run lasting 2*2^AW + GAP + RD_LAT + 2 cycles from the start edge to the done pulse (with CHECK_EN).

Reset
- REQ-028 SHALL, on rst_n low at any time including mid-run, force state IDLE, ram_addr=0, ram_wdata=0, ram_wren=0, busy=0, done=0, err_cnt=0, and clear the pipeline valids.
- REQ-029 SHALL not start a run on the first edge after reset release unless start is high.

Configuration
- REQ-030 SHALL support macro RAM_READBACK_CHECK_EN.
- REQ-031 SHALL, when RAM_READBACK_CHECK_EN is defined, include GAP_WAIT, READ, DRAIN and the compare pipeline as specified.
- REQ-032 SHALL, when RAM_READBACK_CHECK_EN is undefined, go WRITE -> FINISH directly, drive no read addresses, and tie err_cnt to 0.

Verification
- REQ-033 SHALL cover a golden run: ideal RAM model, RD_LAT=2, seed=8'h10, start -> 32 writes with data 8'h10..8'h2F, done pulse after 72 cycles, err_cnt=0.
- REQ-034 SHALL cover fault injection: model corrupts addresses 3 and 17 on read -> err_cnt=2.
- REQ-035 SHALL cover saturation: model returns ~expected on every read -> err_cnt=32; with AW=7 -> err_cnt=63.
- REQ-036 SHALL cover start while busy: second start pulse at cycle 10 -> ignored, a single done pulse, seed unchanged.
- REQ-037 SHALL cover reset mid-run: rst_n low during READ at address 9 -> all outputs reset, no done pulse; a new start completes cleanly.
- REQ-038 SHALL cover the macro-undefined build: seed=8'hF0 -> writes 8'hF0..8'h0F (wrapping), done after 34 cycles, err_cnt=0, no read-phase addresses.
